// File: rtl/usb_sample_player.sv
// usb_sample_player: buffers 32-bit USB words in a FIFO and plays them out as signed 8-bit samples at a programmable rate
//
// Ports:
//   clk, reset_n            system clock, asynchronous active-low reset
//   usb_rd_data/_valid      packed sample words from the host (byte 0 plays first)
//   usb_rd_full             registered FIFO-full flag; writes while full are dropped
//   enable, flush           playback enable, one-cycle synchronous clear
//   rate_div, prefill       sample period (rate_div+1 clocks), start/resume word level
//   sample_out/_valid       sample to the DDS block and its one-cycle update strobe
//   level                   words stored in the FIFO (a word leaves when the unpacker fetches it)
//   underrun_count          saturating count of missed sample ticks
//   overflow_count          saturating count of dropped words
//
// Optional build macro USB_SAMPLE_PLAYER_OVF_CNT_EN enables overflow_count;
// without it overflow_count is tied to zero.
module usb_sample_player #(
    parameter int DEPTH_LOG2 = 10,
    parameter int RATE_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [31:0]           usb_rd_data,
    input  logic                  usb_rd_data_valid,
    output logic                  usb_rd_full,
    input  logic                  enable,
    input  logic                  flush,
    input  logic [RATE_WIDTH-1:0] rate_div,
    input  logic [DEPTH_LOG2:0]   prefill,
    output logic [7:0]            sample_out,
    output logic                  sample_valid,
    output logic [DEPTH_LOG2:0]   level,
    output logic [31:0]           underrun_count,
    output logic [31:0]           overflow_count
);
    localparam int PW = DEPTH_LOG2 + 1;
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {IDLE, PRIME, PLAY, STARVED} state_t;

    // Reset asserts asynchronously but releases on a clock edge.
    logic [1:0] rst_sync;
    logic       rst_n;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rst_sync <= '0;
        else rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    logic [31:0]           mem [DEPTH];
    logic [31:0]           mem_q;
    logic [31:0]           hold;
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         level_next;
    logic [1:0]            idx;
    logic                  hold_valid;
    logic                  rd_pend;
    logic [RATE_WIDTH-1:0] cnt;
    state_t                state;
    logic                  wr_en;
    logic                  rd_en;
    logic                  tick;
    logic                  take;
    logic                  go_play;

    // Modular subtraction keeps level correct across pointer wrap.
    assign level   = wr_ptr - rd_ptr;
    assign wr_en   = usb_rd_data_valid && !usb_rd_full && !flush;
    assign go_play = enable && (state == PRIME || state == STARVED) && (level >= prefill);
    assign tick    = state == PLAY && cnt == rate_div;
    assign take    = enable && tick && hold_valid;
    // Fetch only when playback is running (or about to), so the prefill
    // threshold is measured against words still sitting in the FIFO.
    assign rd_en   = enable && !flush && level != '0 && !rd_pend &&
                     (!hold_valid || (take && idx == 2'd3)) && (state == PLAY || go_play);
    assign level_next = flush ? '0 : level + PW'(wr_en) - PW'(rd_en);

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[DEPTH_LOG2-1:0]] <= usb_rd_data;
        mem_q <= mem[rd_ptr[DEPTH_LOG2-1:0]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            usb_rd_full    <= 1'b0;
            hold           <= '0;
            hold_valid     <= 1'b0;
            rd_pend        <= 1'b0;
            idx            <= '0;
            cnt            <= '0;
            state          <= IDLE;
            sample_out     <= '0;
            sample_valid   <= 1'b0;
            underrun_count <= '0;
        end else begin
            usb_rd_full  <= level_next == PW'(DEPTH);
            sample_valid <= 1'b0;
            if (flush) begin
                rd_ptr         <= wr_ptr;
                hold_valid     <= 1'b0;
                rd_pend        <= 1'b0;
                idx            <= '0;
                cnt            <= '0;
                underrun_count <= '0;
                state          <= enable ? PRIME : IDLE;
                if (!enable) sample_out <= '0;
            end else begin
                if (wr_en) wr_ptr <= wr_ptr + PW'(1);
                if (rd_en) rd_ptr <= rd_ptr + PW'(1);
                rd_pend <= rd_en;
                // A fetch lands one cycle after issue; it only happens when the
                // holding register is empty, so it never collides with a take.
                if (rd_pend) begin
                    hold       <= mem_q;
                    hold_valid <= 1'b1;
                    idx        <= '0;
                end else if (take) begin
                    idx <= idx + 2'd1;
                    if (idx == 2'd3) hold_valid <= 1'b0;
                end
                cnt <= (state != PLAY || tick) ? '0 : cnt + RATE_WIDTH'(1);
                if (!enable) begin
                    state      <= IDLE;
                    sample_out <= '0;
                end else begin
                    case (state)
                        IDLE:    state <= PRIME;
                        PRIME:   if (level >= prefill) state <= PLAY;
                        STARVED: if (level >= prefill) state <= PLAY;
                        PLAY: begin
                            if (tick && hold_valid) begin
                                sample_out   <= hold[{idx, 3'b000} +: 8];
                                sample_valid <= 1'b1;
                            end else if (tick) begin
                                if (underrun_count != '1) underrun_count <= underrun_count + 32'd1;
                                state <= STARVED;
                            end
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end

`ifdef USB_SAMPLE_PLAYER_OVF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) overflow_count <= '0;
        else if (flush) overflow_count <= '0;
        else if (usb_rd_data_valid && usb_rd_full && overflow_count != '1) overflow_count <= overflow_count + 32'd1;
    end
`else
    assign overflow_count = '0;
`endif

endmodule

// File: tb/tb_usb_sample_player.sv
// tb_usb_sample_player: randomized self-checking bench for usb_sample_player against a byte-queue model
module tb_usb_sample_player;
    localparam int DL = 4;
    localparam int RW = 16;
`ifdef USB_SAMPLE_PLAYER_OVF_CNT_EN
    localparam int EXP_OVF = 4;
`else
    localparam int EXP_OVF = 0;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [31:0]   usb_rd_data = '0;
    logic          usb_rd_data_valid = 1'b0;
    logic          enable = 1'b0;
    logic          flush = 1'b0;
    logic [RW-1:0] rate_div = '0;
    logic [DL:0]   prefill = '0;
    logic          usb_rd_full;
    logic          sample_valid;
    logic [7:0]    sample_out;
    logic [DL:0]   level;
    logic [31:0]   underrun_count;
    logic [31:0]   overflow_count;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [7:0]  exp_q[$];
    logic [31:0] wq[$];
    logic [7:0]  got_v[$];
    int          got_t[$];
    int          got_l[$];

    usb_sample_player #(.DEPTH_LOG2(DL), .RATE_WIDTH(RW)) dut (
        .clk(clk), .reset_n(reset_n),
        .usb_rd_data(usb_rd_data), .usb_rd_data_valid(usb_rd_data_valid), .usb_rd_full(usb_rd_full),
        .enable(enable), .flush(flush), .rate_div(rate_div), .prefill(prefill),
        .sample_out(sample_out), .sample_valid(sample_valid), .level(level),
        .underrun_count(underrun_count), .overflow_count(overflow_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Model: every accepted word contributes four bytes, lowest byte first.
    function automatic void add_word(input logic [31:0] w);
        for (int b = 0; b < 4; b++) exp_q.push_back(w[8*b +: 8]);
    endfunction

    task automatic start(input bit en, input int pf, input int rd);
        @(negedge clk);
        enable = en; prefill = (DL+1)'(pf); rate_div = RW'(rd); flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        exp_q = {};
    endtask

    task automatic push_words();
        for (int i = 0; i < wq.size(); i++) begin
            @(negedge clk);
            usb_rd_data = wq[i]; usb_rd_data_valid = 1'b1;
        end
        @(negedge clk);
        usb_rd_data_valid = 1'b0;
    endtask

    task automatic collect(input int n);
        got_v = {}; got_t = {}; got_l = {};
        for (int k = 0; k < n; k++) begin
            int w;
            w = 0;
            while (!sample_valid && w < 64) begin @(negedge clk); w++; end
            if (!sample_valid) break;
            got_v.push_back(sample_out); got_t.push_back(cyc); got_l.push_back(int'(level));
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (level !== 0) begin errors++; $display("FAIL reset_level got %0d exp 0", level); end
        checks++; if (usb_rd_full !== 1'b0) begin errors++; $display("FAIL reset_full got %0b exp 0", usb_rd_full); end
        checks++; if (sample_out !== 8'h00) begin errors++; $display("FAIL reset_sample got %0h exp 0", sample_out); end
        checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", sample_valid); end
        checks++; if (underrun_count !== 0) begin errors++; $display("FAIL reset_underrun got %0d exp 0", underrun_count); end
        checks++; if (overflow_count !== 0) begin errors++; $display("FAIL reset_overflow got %0d exp 0", overflow_count); end
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (level !== 0 || sample_out !== 8'h00) begin errors++; $display("FAIL reset_release got %0d/%0h exp 0/0", level, sample_out); end
    endtask

    task automatic test_basic();
        int wt;
        bit saw;
        start(1'b1, 2, 3);
        wq = {32'h04030201, 32'h08070605};
        foreach (wq[i]) add_word(wq[i]);
        push_words();
        collect(8);
        checks++; if (got_v.size() != 8) begin errors++; $display("FAIL basic_count got %0d exp 8", got_v.size()); end
        for (int k = 0; k < got_v.size(); k++) begin
            logic [7:0] e;
            e = exp_q.pop_front();
            checks++; if (got_v[k] !== e) begin errors++; $display("FAIL basic_byte%0d got %0h exp %0h", k, got_v[k], e); end
            if (k > 0) begin
                checks++; if (got_t[k] - got_t[k-1] != 4) begin errors++; $display("FAIL basic_period%0d got %0d exp 4", k, got_t[k] - got_t[k-1]); end
            end
        end
        if (got_v.size() == 8) begin
            checks++; if (got_l[0] != 1) begin errors++; $display("FAIL basic_level1 got %0d exp 1", got_l[0]); end
            checks++; if (got_l[7] != 0) begin errors++; $display("FAIL basic_level8 got %0d exp 0", got_l[7]); end
        end
        wt = 0; saw = 0;
        while (underrun_count != 1 && wt < 40) begin @(negedge clk); wt++; if (sample_valid) saw = 1; end
        checks++; if (underrun_count !== 1) begin errors++; $display("FAIL underrun_first got %0d exp 1", underrun_count); end
        checks++; if (sample_out !== 8'h08 || saw) begin errors++; $display("FAIL underrun_hold got %0h/%0b exp 08/0", sample_out, saw); end
        repeat (20) @(negedge clk);
        checks++; if (underrun_count !== 1) begin errors++; $display("FAIL starved_nocount got %0d exp 1", underrun_count); end
        wq = {$urandom, $urandom};
        foreach (wq[i]) add_word(wq[i]);
        push_words();
        collect(8);
        checks++; if (got_v.size() != 8) begin errors++; $display("FAIL resume_count got %0d exp 8", got_v.size()); end
        for (int k = 0; k < got_v.size(); k++) begin
            logic [7:0] e;
            e = exp_q.pop_front();
            checks++; if (got_v[k] !== e) begin errors++; $display("FAIL resume_byte%0d got %0h exp %0h", k, got_v[k], e); end
        end
        checks++; if (underrun_count !== 1) begin errors++; $display("FAIL resume_underrun got %0d exp 1", underrun_count); end
        enable = 1'b0;
        @(negedge clk);
        checks++; if (sample_out !== 8'h00) begin errors++; $display("FAIL disable_zero got %0h exp 0", sample_out); end
    endtask

    task automatic test_sign();
        int sx[4];
        sx = '{0, 127, -1, -128};
        start(1'b1, 1, $urandom_range(4, 1));
        wq = {32'h80FF7F00};
        push_words();
        collect(4);
        checks++; if (got_v.size() != 4) begin errors++; $display("FAIL sign_count got %0d exp 4", got_v.size()); end
        for (int k = 0; k < got_v.size(); k++) begin
            checks++; if (int'($signed(got_v[k])) != sx[k]) begin errors++; $display("FAIL sign_byte%0d got %0d exp %0d", k, $signed(got_v[k]), sx[k]); end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 3; it++) begin
            int rd, pf, n, wt;
            rd = $urandom_range(4, 1);
            pf = $urandom_range(4, 1);
            n = $urandom_range(12, 4);
            start(1'b1, pf, rd);
            wq = {};
            for (int i = 0; i < n; i++) begin wq.push_back($urandom); add_word(wq[i]); end
            fork
                push_words();
                collect(4 * n);
            join
            checks++; if (got_v.size() != 4 * n) begin errors++; $display("FAIL rand_count got %0d exp %0d", got_v.size(), 4 * n); end
            for (int k = 0; k < got_v.size(); k++) begin
                logic [7:0] e;
                e = exp_q.pop_front();
                checks++; if (got_v[k] !== e) begin errors++; $display("FAIL rand_byte%0d got %0h exp %0h", k, got_v[k], e); end
                if (k > 0) begin
                    checks++; if (got_t[k] - got_t[k-1] != rd + 1) begin errors++; $display("FAIL rand_period%0d got %0d exp %0d", k, got_t[k] - got_t[k-1], rd + 1); end
                end
            end
            wt = 0;
            while (underrun_count == 0 && wt < 40) begin @(negedge clk); wt++; end
            checks++; if (underrun_count !== 1) begin errors++; $display("FAIL rand_underrun got %0d exp 1", underrun_count); end
        end
    endtask

    task automatic test_overflow();
        start(1'b0, 16, 1);
        wq = {};
        for (int i = 0; i < 20; i++) wq.push_back($urandom);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 15) begin
                checks++; if (usb_rd_full !== 1'b0) begin errors++; $display("FAIL ovf_full15 got %0b exp 0", usb_rd_full); end
            end
            if (i == 16) begin
                checks++; if (usb_rd_full !== 1'b1) begin errors++; $display("FAIL ovf_full16 got %0b exp 1", usb_rd_full); end
            end
            usb_rd_data = wq[i]; usb_rd_data_valid = 1'b1;
        end
        @(negedge clk);
        usb_rd_data_valid = 1'b0;
        checks++; if (usb_rd_full !== 1'b1) begin errors++; $display("FAIL ovf_full got %0b exp 1", usb_rd_full); end
        checks++; if (level !== 16) begin errors++; $display("FAIL ovf_level got %0d exp 16", level); end
        checks++; if (overflow_count !== EXP_OVF) begin errors++; $display("FAIL ovf_count got %0d exp %0d", overflow_count, EXP_OVF); end
        for (int i = 0; i < 16; i++) add_word(wq[i]);
        enable = 1'b1;
        collect(64);
        checks++; if (got_v.size() != 64) begin errors++; $display("FAIL ovf_play_count got %0d exp 64", got_v.size()); end
        for (int k = 0; k < got_v.size(); k++) begin
            logic [7:0] e;
            e = exp_q.pop_front();
            checks++; if (got_v[k] !== e) begin errors++; $display("FAIL ovf_byte%0d got %0h exp %0h", k, got_v[k], e); end
        end
    endtask

    task automatic test_flush();
        int wt;
        bit saw;
        logic [7:0] last;
        start(1'b1, 0, 3);
        wt = 0;
        while (underrun_count == 0 && wt < 40) begin @(negedge clk); wt++; end
        checks++; if (underrun_count === 0) begin errors++; $display("FAIL flush_pre_underrun got 0 exp nonzero"); end
        prefill = (DL+1)'(1);
        wq = {$urandom, $urandom, $urandom};
        push_words();
        collect(2);
        checks++; if (got_v.size() != 2 || got_v[0] !== wq[0][7:0] || got_v[1] !== wq[0][15:8]) begin
            errors++; $display("FAIL flush_pre_bytes got %0d samples exp 2 of %0h", got_v.size(), wq[0]);
        end
        last = sample_out;
        flush = 1'b1; usb_rd_data = $urandom; usb_rd_data_valid = 1'b1;
        @(negedge clk);
        flush = 1'b0; usb_rd_data_valid = 1'b0;
        checks++; if (level !== 0) begin errors++; $display("FAIL flush_level got %0d exp 0", level); end
        checks++; if (underrun_count !== 0) begin errors++; $display("FAIL flush_underrun got %0d exp 0", underrun_count); end
        checks++; if (usb_rd_full !== 1'b0 || overflow_count !== 0) begin errors++; $display("FAIL flush_full_ovf got %0b/%0d exp 0/0", usb_rd_full, overflow_count); end
        checks++; if (sample_out !== last) begin errors++; $display("FAIL flush_sample got %0h exp %0h", sample_out, last); end
        saw = 0;
        repeat (20) begin @(negedge clk); if (sample_valid) saw = 1; end
        checks++; if (saw || underrun_count !== 0 || sample_out !== last) begin
            errors++; $display("FAIL flush_prime got valid=%0b ur=%0d out=%0h exp 0/0/%0h", saw, underrun_count, sample_out, last);
        end
        exp_q = {};
        wq = {$urandom};
        add_word(wq[0]);
        push_words();
        collect(4);
        checks++; if (got_v.size() != 4) begin errors++; $display("FAIL flush_resume_count got %0d exp 4", got_v.size()); end
        for (int k = 0; k < got_v.size(); k++) begin
            logic [7:0] e;
            e = exp_q.pop_front();
            checks++; if (got_v[k] !== e) begin errors++; $display("FAIL flush_resume_byte%0d got %0h exp %0h", k, got_v[k], e); end
        end
    endtask

    task automatic test_reset_midstream();
        bit saw;
        start(1'b1, 1, 3);
        wq = {$urandom | 32'h1, $urandom};
        push_words();
        collect(1);
        checks++; if (got_v.size() != 1) begin errors++; $display("FAIL mid_first got %0d exp 1", got_v.size()); end
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        checks++; if (sample_out !== 8'h00 || sample_valid !== 1'b0) begin errors++; $display("FAIL mid_sample got %0h/%0b exp 0/0", sample_out, sample_valid); end
        checks++; if (level !== 0 || usb_rd_full !== 1'b0) begin errors++; $display("FAIL mid_level got %0d/%0b exp 0/0", level, usb_rd_full); end
        checks++; if (underrun_count !== 0 || overflow_count !== 0) begin errors++; $display("FAIL mid_counts got %0d/%0d exp 0/0", underrun_count, overflow_count); end
        enable = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        saw = 0;
        repeat (20) begin @(negedge clk); if (sample_valid) saw = 1; end
        checks++; if (level !== 0 || sample_out !== 8'h00 || saw) begin errors++; $display("FAIL mid_after got %0d/%0h/%0b exp 0/0/0", level, sample_out, saw); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sign();
        test_random();
        test_overflow();
        test_flush();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
